fan_tx_scheduler: RTL
=====================

# fan_tx_scheduler

Sequences the shared OOK packet generator between the two command sources: front-panel buttons and the UART command decoder. Each granted request becomes a burst of REPEATS identical packets with a fixed inter-packet gap. Buttons have priority over UART. The block sits between the command sources and `packet_generator`, and drives its `start_packet`/`cmd` inputs while monitoring its `sending` output.

## Interface
Parameters:
- `CMD_W`, 3, width of the fan command code.
- `REPEATS`, 4, packets per burst; a value of 0 is treated as 1.
- `GAP_CYCLES`, 120000, idle `ref_clk` cycles after each packet (10 ms at 12 MHz); a value of 0 is treated as 1.
- `START_TIMEOUT`, 64, maximum cycles from the `start_packet` pulse to `sending` rising.

Ports:
- `ref_clk`  in  1  system clock (12 MHz); the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `btn_req`  in  1  single-cycle request from the button decoder.
- `btn_cmd`  in  CMD_W  command accompanying `btn_req`.
- `uart_req`  in  1  single-cycle request from the UART decoder.
- `uart_cmd`  in  CMD_W  command accompanying `uart_req`.
- `sending`  in  1  high while the packet generator transmits.
- `start_packet`  out  1  registered single-cycle start pulse to the generator.
- `cmd`  out  CMD_W  command for the burst; held stable from grant to return to IDLE.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `grant_src`  out  1  source of the current burst: 0 = button, 1 = UART.
- `burst_done`  out  1  single-cycle pulse when a burst completes normally.
- `timeout`  out  1  single-cycle pulse when a burst is aborted.

## Operation
- Each source has one pending slot holding a valid bit and a command.
  - A request sets the slot's valid bit and overwrites its command (latest request wins).
  - The slot clears when the FSM grants that source.
  - If a request arrives in the same cycle as the grant of that source, the new request wins: the slot stays valid with the new command, and the granted burst uses the old command.
- FSM states: IDLE, START, WAIT_HI, WAIT_LO, GAP.
  - **IDLE:** if the button slot is valid, grant the button source; otherwise, if the UART slot is valid, grant UART.
    - On grant: load `cmd` and `grant_src`, set `remaining = REPEATS`, go to START.
  - **START:** assert `start_packet` for one cycle, clear the timeout counter, go to WAIT_HI.
  - **WAIT_HI:**
    - `sending` = 1: go to WAIT_LO.
    - Otherwise, when the timeout counter reaches START_TIMEOUT: pulse `timeout`, go to IDLE, and discard the remaining repeats.
  - **WAIT_LO:** `sending` = 0: decrement `remaining`, clear the gap counter, go to GAP.
  - **GAP:** count GAP_CYCLES cycles, then:
    - `remaining` ≠ 0: go to START.
    - `remaining` = 0: pulse `burst_done` and go to IDLE.
- Bursts are never preempted. A button request during a UART burst waits for that burst to finish, then wins arbitration.
- Counter widths:
  - `remaining`: $clog2(REPEATS+1).
  - Gap counter: $clog2(GAP_CYCLES+1).
  - Timeout counter: $clog2(START_TIMEOUT+1).
  - Counters saturate and never wrap.

## Timing
- Reset values:
  - `start_packet`, `busy`, `burst_done`, `timeout`, `grant_src` = 0.
  - `cmd` = 0.
  - Both pending slots invalid; FSM in IDLE.
- Reset asserted mid-burst clears all state immediately (asynchronous). No further `start_packet` is issued.
- All outputs are registered.
- Latency:
  - Request sampled at edge N sets the slot at N.
  - IDLE grants at N+1.
  - `start_packet` is high during the cycle following edge N+2.
- `busy` rises on the same edge that enters START and falls on the edge that enters IDLE.
- `burst_done` and `timeout` are coincident with the transition back to IDLE.
- Successive `start_packet` pulses within a burst are separated by at least GAP_CYCLES + 3 cycles, plus packet length.

## Test plan
Bench parameters for all scenarios: REPEATS=2, GAP_CYCLES=4, START_TIMEOUT=8. A generator model raises `sending` 2 cycles after `start_packet` and holds it for 10 cycles.

- **Single UART burst:** `uart_req` with `uart_cmd`=3 → exactly 2 `start_packet` pulses, `cmd`=3, `grant_src`=1, one `burst_done` pulse, then `busy`=0.
- **Priority:** `btn_req` (cmd 1) and `uart_req` (cmd 4) in the same cycle → button burst (cmd 1, 2 packets) first, then UART burst (cmd 4); 4 pulses total.
- **Latest wins:** during an active burst, `btn_req` cmd 2 then `btn_req` cmd 0 → the following burst uses `cmd`=0; only one extra burst occurs.
- **Timeout:** model never raises `sending` → `timeout` pulses 8 cycles after `start_packet`, FSM returns to IDLE, no second packet; a subsequently pending request is then served normally.
- **Async reset mid-burst:** assert `reset` during WAIT_LO → all outputs 0 in the same cycle; after release, no `start_packet` occurs without a new request.
- **Simultaneous grant and request:** `uart_req` cmd 5 arrives on the grant edge of a UART burst with cmd 6 → burst with cmd 6, then a second burst with cmd 5.

Source files
------------

// File: rtl/fan_tx_scheduler_if.sv
// Signal bundle between the command sources, the burst scheduler and the OOK packet generator.
// The scheduler connects through the slave modport; the environment drives the master side.
interface fan_tx_scheduler_if #(
    parameter int unsigned CMD_W = 3
);
    logic             btn_req;
    logic [CMD_W-1:0] btn_cmd;
    logic             uart_req;
    logic [CMD_W-1:0] uart_cmd;
    logic             sending;
    logic             start_packet;
    logic [CMD_W-1:0] cmd;
    logic             busy;
    logic             grant_src;
    logic             burst_done;
    logic             timeout;

    modport master (
        output btn_req, btn_cmd, uart_req, uart_cmd, sending,
        input  start_packet, cmd, busy, grant_src, burst_done, timeout
    );

    modport slave (
        input  btn_req, btn_cmd, uart_req, uart_cmd, sending,
        output start_packet, cmd, busy, grant_src, burst_done, timeout
    );
endinterface

// File: rtl/fan_tx_scheduler.sv
// Arbitrates button and UART fan commands onto the shared OOK packet generator, sending each
// granted command as a burst of REPEATS packets separated by GAP_CYCLES idle cycles.
module fan_tx_scheduler #(
    parameter int unsigned CMD_W         = 3,
    parameter int unsigned REPEATS       = 4,
    parameter int unsigned GAP_CYCLES    = 120000,
    parameter int unsigned START_TIMEOUT = 64
) (
    input logic               ref_clk,
    input logic               reset,
    fan_tx_scheduler_if.slave bus_io
);
    localparam int unsigned RepEff = (REPEATS == 0) ? 1 : REPEATS;
    localparam int unsigned GapEff = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;
    localparam int unsigned RemW   = $clog2(RepEff + 1);
    localparam int unsigned GapW   = $clog2(GapEff + 1);
    localparam int unsigned ToW    = (START_TIMEOUT == 0) ? 1 : $clog2(START_TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StStart, StWaitHi, StWaitLo, StGap} state_e;

    state_e           state_q, state_d;
    logic             btn_valid_q, btn_valid_d;
    logic [CMD_W-1:0] btn_cmd_q, btn_cmd_d;
    logic             uart_valid_q, uart_valid_d;
    logic [CMD_W-1:0] uart_cmd_q, uart_cmd_d;
    logic [RemW-1:0]  rem_q, rem_d;
    logic [GapW-1:0]  gap_cnt_q, gap_cnt_d, gap_next;
    logic [ToW-1:0]   to_cnt_q, to_cnt_d, to_next;
    logic             start_packet_q, start_packet_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic             busy_q, busy_d;
    logic             grant_src_q, grant_src_d;
    logic             burst_done_q, burst_done_d;
    logic             timeout_q, timeout_d;
    logic             grant_btn, grant_uart;

    assign gap_next = (gap_cnt_q == '1) ? gap_cnt_q : gap_cnt_q + 1'b1;
    assign to_next  = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        rem_d          = rem_q;
        gap_cnt_d      = gap_cnt_q;
        to_cnt_d       = to_cnt_q;
        cmd_d          = cmd_q;
        busy_d         = busy_q;
        grant_src_d    = grant_src_q;
        start_packet_d = 1'b0;
        burst_done_d   = 1'b0;
        timeout_d      = 1'b0;
        grant_btn      = 1'b0;
        grant_uart     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (btn_valid_q) begin
                    grant_btn   = 1'b1;
                    cmd_d       = btn_cmd_q;
                    grant_src_d = 1'b0;
                end else if (uart_valid_q) begin
                    grant_uart  = 1'b1;
                    cmd_d       = uart_cmd_q;
                    grant_src_d = 1'b1;
                end
                if (btn_valid_q || uart_valid_q) begin
                    rem_d   = RemW'(RepEff);
                    busy_d  = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                start_packet_d = 1'b1;
                to_cnt_d       = '0;
                state_d        = StWaitHi;
            end
            StWaitHi: begin
                if (bus_io.sending) begin
                    state_d = StWaitLo;
                end else begin
                    to_cnt_d = to_next;
                    // Generator never answered: abandon the whole burst.
                    if (to_next >= ToW'(START_TIMEOUT)) begin
                        timeout_d = 1'b1;
                        busy_d    = 1'b0;
                        rem_d     = '0;
                        state_d   = StIdle;
                    end
                end
            end
            StWaitLo: begin
                if (!bus_io.sending) begin
                    rem_d     = (rem_q == '0) ? rem_q : rem_q - 1'b1;
                    gap_cnt_d = '0;
                    state_d   = StGap;
                end
            end
            StGap: begin
                gap_cnt_d = gap_next;
                if (gap_next >= GapW'(GapEff)) begin
                    if (rem_q != '0) begin
                        state_d = StStart;
                    end else begin
                        burst_done_d = 1'b1;
                        busy_d       = 1'b0;
                        state_d      = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A request landing on its own grant edge re-arms the slot; the burst keeps the old command.
    always_comb begin
        btn_valid_d  = btn_valid_q;
        btn_cmd_d    = btn_cmd_q;
        uart_valid_d = uart_valid_q;
        uart_cmd_d   = uart_cmd_q;
        if (bus_io.btn_req) begin
            btn_valid_d = 1'b1;
            btn_cmd_d   = bus_io.btn_cmd;
        end else if (grant_btn) begin
            btn_valid_d = 1'b0;
        end
        if (bus_io.uart_req) begin
            uart_valid_d = 1'b1;
            uart_cmd_d   = bus_io.uart_cmd;
        end else if (grant_uart) begin
            uart_valid_d = 1'b0;
        end
    end

    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            btn_valid_q    <= 1'b0;
            btn_cmd_q      <= '0;
            uart_valid_q   <= 1'b0;
            uart_cmd_q     <= '0;
            rem_q          <= '0;
            gap_cnt_q      <= '0;
            to_cnt_q       <= '0;
            start_packet_q <= 1'b0;
            cmd_q          <= '0;
            busy_q         <= 1'b0;
            grant_src_q    <= 1'b0;
            burst_done_q   <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            btn_valid_q    <= btn_valid_d;
            btn_cmd_q      <= btn_cmd_d;
            uart_valid_q   <= uart_valid_d;
            uart_cmd_q     <= uart_cmd_d;
            rem_q          <= rem_d;
            gap_cnt_q      <= gap_cnt_d;
            to_cnt_q       <= to_cnt_d;
            start_packet_q <= start_packet_d;
            cmd_q          <= cmd_d;
            busy_q         <= busy_d;
            grant_src_q    <= grant_src_d;
            burst_done_q   <= burst_done_d;
            timeout_q      <= timeout_d;
        end
    end

    assign bus_io.start_packet = start_packet_q;
    assign bus_io.cmd          = cmd_q;
    assign bus_io.busy         = busy_q;
    assign bus_io.grant_src    = grant_src_q;
    assign bus_io.burst_done   = burst_done_q;
    assign bus_io.timeout      = timeout_q;
endmodule
